// File: rtl/fifo_depth16_buf.sv
// 16-entry register FIFO feeding the 2:1 output mux tree (L0/OFIFO row buffer).
// Latency: a popped word is registered onto out one cycle after the accepted read.
// Backpressure: writes are refused when full and reads when empty; each refusal sets a sticky flag.
//
// Ports:
//   clk      rising-edge clock
//   reset    asynchronous active-low reset
//   wr, in   write request and write data (captured when not full)
//   rd       read request (head popped when not empty)
//   out      registered read data, holds its value between pops
//   o_valid  one-cycle pulse marking newly popped data on out
//   full     16 entries held
//   empty    no entries held
//   count    number of entries held, 0..16
//   ovf      sticky: a write was attempted while full
//   udf      sticky: a read was attempted while empty
module fifo_depth16_buf #(
   parameter int bw = 8
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          wr,
   input  logic [bw-1:0] in,
   input  logic          rd,
   output logic [bw-1:0] out,
   output logic          o_valid,
   output logic          full,
   output logic          empty,
   output logic [4:0]    count,
   output logic          ovf,
   output logic          udf
);

   // Pointers carry a wrap bit above the 4 index bits so full and empty
   // can be told apart when the index bits match.
   logic [4:0]    wr_ptr_q, wr_ptr_d;
   logic [4:0]    rd_ptr_q, rd_ptr_d;
   logic [4:0]    count_q, count_d;
   logic [bw-1:0] out_q, out_d;
   logic          o_valid_q, o_valid_d;
   logic          ovf_q, ovf_d;
   logic          udf_q, udf_d;
   logic [bw-1:0] mem_q [16];

   logic          wr_acc, rd_acc;
   logic [bw-1:0] rd_word;

   assign empty = (wr_ptr_q == rd_ptr_q);
   assign full  = (wr_ptr_q[3:0] == rd_ptr_q[3:0]) & (wr_ptr_q[4] != rd_ptr_q[4]);

   // Acceptance uses pre-edge state only: a read in the same cycle never
   // makes room for a write, and a write never feeds a same-cycle read.
   assign wr_acc = wr & ~full;
   assign rd_acc = rd & ~empty;

   // Read select: balanced 16:1 tree of 2:1 muxes, one rd_ptr bit per
   // stage, no priority terms.
   logic [bw-1:0] sel1 [8];
   logic [bw-1:0] sel2 [4];
   logic [bw-1:0] sel3 [2];

   for (genvar i = 0; i < 8; i++) begin : g_sel1
      assign sel1[i] = rd_ptr_q[0] ? mem_q[2*i+1] : mem_q[2*i];
   end
   for (genvar i = 0; i < 4; i++) begin : g_sel2
      assign sel2[i] = rd_ptr_q[1] ? sel1[2*i+1] : sel1[2*i];
   end
   for (genvar i = 0; i < 2; i++) begin : g_sel3
      assign sel3[i] = rd_ptr_q[2] ? sel2[2*i+1] : sel2[2*i];
   end
   assign rd_word = rd_ptr_q[3] ? sel3[1] : sel3[0];

   always_comb begin
      wr_ptr_d  = wr_ptr_q;
      rd_ptr_d  = rd_ptr_q;
      out_d     = out_q;
      o_valid_d = rd_acc;
      count_d   = count_q + {4'd0, wr_acc} - {4'd0, rd_acc};
      ovf_d     = ovf_q | (wr & full);
      udf_d     = udf_q | (rd & empty);
      if (wr_acc) begin
         wr_ptr_d = wr_ptr_q + 5'd1;
      end
      if (rd_acc) begin
         rd_ptr_d = rd_ptr_q + 5'd1;
         out_d    = rd_word;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_ptr_q  <= '0;
         rd_ptr_q  <= '0;
         count_q   <= '0;
         out_q     <= '0;
         o_valid_q <= 1'b0;
         ovf_q     <= 1'b0;
         udf_q     <= 1'b0;
      end else begin
         wr_ptr_q  <= wr_ptr_d;
         rd_ptr_q  <= rd_ptr_d;
         count_q   <= count_d;
         out_q     <= out_d;
         o_valid_q <= o_valid_d;
         ovf_q     <= ovf_d;
         udf_q     <= udf_d;
      end
   end

   // Storage is not reset; the pointers alone define which entries are live.
   always_ff @(posedge clk) begin
      if (wr_acc) begin
         mem_q[wr_ptr_q[3:0]] <= in;
      end
   end

   assign out     = out_q;
   assign o_valid = o_valid_q;
   assign count   = count_q;
   assign ovf     = ovf_q;
   assign udf     = udf_q;

endmodule

// File: tb/tb_fifo_depth16_buf.sv
module tb_fifo_depth16_buf;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       wr = 1'b0;
   logic       rd = 1'b0;
   logic [7:0] din = 8'h00;
   logic [7:0] dout;
   logic       o_valid, full, empty, ovf, udf;
   logic [4:0] count;

   fifo_depth16_buf #(.bw(8)) dut (
      .clk    (clk),
      .reset  (rst_n),
      .wr     (wr),
      .in     (din),
      .rd     (rd),
      .out    (dout),
      .o_valid(o_valid),
      .full   (full),
      .empty  (empty),
      .count  (count),
      .ovf    (ovf),
      .udf    (udf)
   );

   always #5 clk = ~clk;

   // Reference model: plain queue of stored words plus expected outputs.
   logic [7:0] mq [$];
   logic [7:0] sb [$];
   logic [7:0] exp_out = 8'h00;
   bit         exp_valid = 1'b0;
   bit         m_ovf = 1'b0;
   bit         m_udf = 1'b0;

   int n_vec = 0;
   int n_err = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic check_state();
      chk("count", 32'(count), 32'(mq.size()));
      chk("full", 32'(full), 32'(mq.size() == 16));
      chk("empty", 32'(empty), 32'(mq.size() == 0));
      chk("ovf", 32'(ovf), 32'(m_ovf));
      chk("udf", 32'(udf), 32'(m_udf));
      chk("o_valid", 32'(o_valid), 32'(exp_valid));
      chk("out", 32'(dout), 32'(exp_out));
   endtask

   // One clock of stimulus; called just after a rising edge.
   task automatic step(input bit w, input logic [7:0] d, input bit r);
      bit wa, ra;
      wr  = w;
      din = d;
      rd  = r;
      wa = w && (mq.size() < 16);
      ra = r && (mq.size() > 0);
      if (w && mq.size() == 16) m_ovf = 1'b1;
      if (r && mq.size() == 0) m_udf = 1'b1;
      if (ra) begin
         exp_out = mq.pop_front();
         sb.push_back(exp_out);
      end
      if (wa) mq.push_back(d);
      exp_valid = ra;
      @(posedge clk);
      #1;
      wr = 1'b0;
      rd = 1'b0;
      check_state();
   endtask

   // Reset asserted between edges; outputs must clear without a clock.
   task automatic async_reset();
      wr = 1'b0;
      rd = 1'b0;
      #2;
      rst_n = 1'b0;
      mq.delete();
      sb.delete();
      exp_out = 8'h00;
      exp_valid = 1'b0;
      m_ovf = 1'b0;
      m_udf = 1'b0;
      #1;
      check_state();
      rst_n = 1'b1;
      @(posedge clk);
      #1;
   endtask

   // Monitor: every presented word must be the next one the model popped.
   always @(negedge clk) begin
      if (rst_n && o_valid) begin
         if (sb.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL mon_unexpected: got %0h expected no output", dout);
         end else begin
            chk("mon_out", 32'(dout), 32'(sb.pop_front()));
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, expected end before 200000");
      $fatal(1, "timeout");
   end

   initial begin
      int pw, pr;

      // Fill, overflow, drain.
      async_reset();
      for (int i = 1; i <= 16; i++) step(1'b1, 8'(i), 1'b0);
      step(1'b1, 8'hFF, 1'b0);
      for (int i = 0; i < 16; i++) step(1'b0, 8'h00, 1'b1);

      // Underflow from reset.
      async_reset();
      step(1'b0, 8'h00, 1'b1);

      // Simultaneous wr/rd on empty, then read back.
      async_reset();
      step(1'b1, 8'hA5, 1'b1);
      step(1'b0, 8'h00, 1'b1);
      step(1'b0, 8'h00, 1'b0);

      // Simultaneous wr/rd on full: write refused.
      async_reset();
      for (int i = 0; i < 16; i++) step(1'b1, 8'(i), 1'b0);
      step(1'b1, 8'h77, 1'b1);
      for (int i = 0; i < 15; i++) step(1'b0, 8'h00, 1'b1);
      step(1'b0, 8'h00, 1'b1);

      // Streaming through pointer wrap with 3 words resident.
      async_reset();
      for (int i = 0; i < 3; i++) step(1'b1, 8'(8'hE0 + i), 1'b0);
      for (int i = 0; i < 40; i++) step(1'b1, 8'(i), 1'b1);

      // Reset mid-operation, then first write lands and reads back.
      async_reset();
      for (int i = 0; i < 5; i++) step(1'b1, 8'(8'h50 + i), 1'b0);
      step(1'b0, 8'h00, 1'b1);
      async_reset();
      step(1'b1, 8'h3C, 1'b0);
      step(1'b0, 8'h00, 1'b1);

      // Random traffic with shifting write/read bias and occasional reset.
      for (int ph = 0; ph < 6; ph++) begin
         pw = (ph % 3 == 0) ? 80 : (ph % 3 == 1) ? 25 : 55;
         pr = (ph % 3 == 0) ? 25 : (ph % 3 == 1) ? 80 : 55;
         for (int i = 0; i < 120; i++) begin
            if ($urandom_range(0, 199) == 0) async_reset();
            step($urandom_range(0, 99) < pw, 8'($urandom), $urandom_range(0, 99) < pr);
         end
      end

      step(1'b0, 8'h00, 1'b0);
      step(1'b0, 8'h00, 1'b0);
      chk("sb_drained", 32'(sb.size()), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
